// File: rtl/rr_arbiter_hold.sv
// rr_arbiter_hold: N-way round-robin arbiter for a shared multi-cycle resource.
// A winner keeps its grant for as long as it holds its request, so one grant
// covers a whole burst. A rotating pointer, moved just past each new owner,
// keeps the arbitration fair between requesters.
//
// Optional feature: define ARB_HOLD_LIMIT_EN to cap the number of consecutive
// grant cycles at HOLD_MAX while other requesters wait. The cut-off owner loses
// the grant, and preempt pulses in the first cycle of the new grant. Without
// the macro an owner may hold indefinitely and preempt is tied low.
module rr_arbiter_hold #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 preempt
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(HOLD_MAX + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] gid_q, gid_d;

  logic          winFound;
  logic [IW-1:0] winIdx;
  logic [IW-1:0] winNext;
  int            searchIdx;
  logic          ownerReq;
  logic          doAward;

`ifdef ARB_HOLD_LIMIT_EN
  logic          preempt_q, preempt_d;
  logic          othersReq;
`endif

  // Search the requests starting at the rotation pointer and wrapping around.
  always_comb begin
    winFound  = 1'b0;
    winIdx    = '0;
    searchIdx = 0;
    for (int off = 0; off < N; off++) begin
      searchIdx = (int'(ptr_q) + off) % N;
      if (!winFound && req[searchIdx]) begin
        winFound = 1'b1;
        winIdx   = IW'(searchIdx);
      end
    end
  end

  // Pointer value for after an award: one past the winner, wrapping at N.
  always_comb begin
    if (winIdx == IW'(N - 1)) begin
      winNext = '0;
    end else begin
      winNext = winIdx + IW'(1);
    end
  end

  // Does the current owner still want the resource?
  assign ownerReq = |(req & grant_q);

`ifdef ARB_HOLD_LIMIT_EN
  // Anyone besides the owner waiting decides whether the hold limit bites.
  assign othersReq = |(req & ~grant_q);
`endif

  // Next-state logic: award, hold, hand off, or drop back to idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    doAward = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    preempt_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (winFound) begin
          doAward = 1'b1;
        end
      end

      BUSY: begin
        if (ownerReq) begin
`ifdef ARB_HOLD_LIMIT_EN
          if (cnt_q == CW'(HOLD_MAX)) begin
            if (othersReq) begin
              doAward   = 1'b1;
              preempt_d = 1'b1;
            end else begin
              cnt_d = CW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          if (cnt_q != CW'(HOLD_MAX)) begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end else if (winFound) begin
          doAward = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          gid_d   = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        gid_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (doAward) begin
      state_d         = BUSY;
      ptr_d           = winNext;
      cnt_d           = CW'(1);
      grant_d         = '0;
      grant_d[winIdx] = 1'b1;
      gid_d           = winIdx;
    end
  end

  // State registers; asynchronous reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  // Preempt pulse register, high only in the first cycle of a forced handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// tb_rr_arbiter_hold: directed scenarios plus randomized requests for
// rr_arbiter_hold, checked against a behavioural owner/pointer model.
module tb_rr_arbiter_hold;

  localparam int N        = 4;
  localparam int HOLD_MAX = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         preempt;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model: who owns the resource, where the search starts next,
  // how long the owner has held, and whether the last handoff was forced.
  int mOwner;
  int mPtr;
  int mCnt;
  bit mPre;

  rr_arbiter_hold #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .preempt     (preempt)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    mOwner = -1;
    mPtr   = 0;
    mCnt   = 0;
    mPre   = 0;
  endtask

  task automatic modelAward(input int w);
    mOwner = w;
    mPtr   = (w + 1) % N;
    mCnt   = 1;
  endtask

  // One clock edge of the arbitration rules applied to request vector r.
  task automatic modelStep(input logic [N-1:0] r);
    int w;
    bit others;
    int i;
    w = -1;
    for (int off = 0; off < N; off++) begin
      i = (mPtr + off) % N;
      if (w < 0 && r[i]) w = i;
    end
    others = 0;
    for (int j = 0; j < N; j++) begin
      if (j != mOwner && r[j]) others = 1;
    end
    mPre = 0;
    if (mOwner < 0) begin
      if (w >= 0) modelAward(w);
    end else if (r[mOwner]) begin
`ifdef ARB_HOLD_LIMIT_EN
      if (mCnt == HOLD_MAX) begin
        if (others) begin
          modelAward(w);
          mPre = 1;
        end else begin
          mCnt = 1;
        end
      end else begin
        mCnt = mCnt + 1;
      end
`else
      if (mCnt < HOLD_MAX) mCnt = mCnt + 1;
`endif
    end else if (w >= 0) begin
      modelAward(w);
    end else begin
      mOwner = -1;
      mCnt   = 0;
    end
  endtask

  // Drive req away from the active edge, let one edge pass, sample 1 unit later.
  task automatic applyStimulus(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    modelStep(r);
    #1;
  endtask

  // Compare every output against the model.
  task automatic checkOutput(input string tag);
    logic [N-1:0] expGrant;
    logic [1:0]   expId;
    logic         expValid;
    expGrant = '0;
    expId    = '0;
    if (mOwner >= 0) begin
      expGrant[mOwner] = 1'b1;
      expId            = 2'(mOwner);
    end
    expValid = (mOwner >= 0);

    testsRun++;
    assert (grant === expGrant) else begin
      failCount++;
      $error("[TB] FAIL %s grant got %b expected %b", tag, grant, expGrant);
    end
    testsRun++;
    assert (grant_valid === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s grant_valid got %b expected %b", tag, grant_valid, expValid);
    end
    testsRun++;
    assert (grant_id === expId) else begin
      failCount++;
      $error("[TB] FAIL %s grant_id got %0d expected %0d", tag, grant_id, expId);
    end
    testsRun++;
    assert (preempt === mPre) else begin
      failCount++;
      $error("[TB] FAIL %s preempt got %b expected %b", tag, preempt, mPre);
    end
  endtask

  // Compare grant and preempt against values fixed by the scenario itself.
  task automatic checkExpect(input string tag, input logic [N-1:0] expGrant, input logic expPre);
    testsRun++;
    assert (grant === expGrant) else begin
      failCount++;
      $error("[TB] FAIL %s grant got %b expected %b", tag, grant, expGrant);
    end
    testsRun++;
    assert (preempt === expPre) else begin
      failCount++;
      $error("[TB] FAIL %s preempt got %b expected %b", tag, preempt, expPre);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] expG;

    rst_n = 1'b0;
    req   = '0;
    modelReset();
    #12;
    checkOutput("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: single request held for several cycles.
    applyStimulus(4'b0001);
    checkOutput("single_first");
    checkExpect("single_first_const", 4'b0001, 1'b0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b0001);
      checkExpect("single_hold", 4'b0001, 1'b0);
    end

    // Asynchronous reset mid-burst drops the grant without a clock edge.
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0001);
    checkOutput("after_reset");
    checkExpect("after_reset_const", 4'b0001, 1'b0);

    // Scenario 2: rotation among four contenders.
    doReset();
    applyStimulus(4'b1111);
    checkExpect("rot_first", 4'b0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1111);
      checkOutput("rot_hold");
      r    = 4'b1111;
      r[k] = 1'b0;
      applyStimulus(r);
      expG = '0;
      expG[(k + 1) % N] = 1'b1;
      checkOutput("rot_handoff");
      checkExpect("rot_order", expG, 1'b0);
    end

    // Scenario 3: back-to-back handoff follows rotation from ptr = 2.
    doReset();
    applyStimulus(4'b0010);
    checkExpect("b2b_owner1", 4'b0010, 1'b0);
    applyStimulus(4'b0111);
    checkOutput("b2b_hold");
    applyStimulus(4'b0101);
    checkOutput("b2b_handoff");
    checkExpect("b2b_handoff_const", 4'b0100, 1'b0);

    // Scenario 4: release to idle, then the pointer wraps to 0.
    applyStimulus(4'b0100);
    checkOutput("idle_hold");
    applyStimulus(4'b0000);
    checkOutput("idle_release");
    checkExpect("idle_release_const", 4'b0000, 1'b0);
    applyStimulus(4'b0001);
    checkOutput("idle_wrap");
    checkExpect("idle_wrap_const", 4'b0001, 1'b0);

    // Scenarios 5/6: long hold by requester 0 with requester 3 waiting.
    doReset();
    for (int c = 1; c <= 22; c++) begin
      applyStimulus(4'b1001);
      checkOutput("hold_contended");
`ifdef ARB_HOLD_LIMIT_EN
      if (c <= HOLD_MAX) begin
        checkExpect("limit_owner0", 4'b0001, 1'b0);
      end else if (c == HOLD_MAX + 1) begin
        checkExpect("limit_preempt", 4'b1000, 1'b1);
      end
`else
      checkExpect("nolimit_hold", 4'b0001, 1'b0);
`endif
    end
    // Requester 0 alone: the grant stays put and never preempts.
    applyStimulus(4'b0001);
    checkOutput("alone_first");
    for (int c = 0; c < 20; c++) begin
      applyStimulus(4'b0001);
      checkOutput("alone_hold");
      checkExpect("alone_hold_const", 4'b0001, 1'b0);
    end

    // Randomized requests with bias toward holding the previous vector.
    doReset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
      applyStimulus(r);
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
